// File: rtl/apu_wave_channel_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : apu_wave_channel_if
// Description : CPU-side register write bus for the APU wave channel.
//               master = bus decoder (drives), slave = channel (receives).
//   reg_wr_en  : one-cycle write strobe
//   reg_addr   : register select (0, 2, 3 decoded; 1 ignored)
//   reg_wdata  : write data
// Revision    : 1.0 - initial release
// ============================================================================
interface apu_wave_channel_if;
    logic       reg_wr_en;
    logic [1:0] reg_addr;
    logic [7:0] reg_wdata;

    modport master (
        output reg_wr_en,
        output reg_addr,
        output reg_wdata
    );

    modport slave (
        input reg_wr_en,
        input reg_addr,
        input reg_wdata
    );
endinterface
`default_nettype wire

// File: rtl/apu_wave_channel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : apu_wave_channel
// Description : Stepped waveform generator (triangle or rising sawtooth),
//               gated by a linear counter and a length counter.
//   clk           : system clock (CPU rate)
//   reset         : synchronous, active-high
//   bus           : register write bus (slave modport)
//   qframe_tick_i : quarter-frame enable, clocks the linear counter
//   hframe_tick_i : half-frame enable, clocks the length counter
//   ch_enable_i   : channel enable; 0 holds the length counter at 0
//   wave_o        : current sample
//   active_o      : length counter is non-zero
// Revision    : 1.0 - initial release
// ============================================================================
module apu_wave_channel #(
    parameter int OUT_W   = 4,
    parameter int MODE    = 0,
    parameter int TIMER_W = 11
) (
    input  wire logic             clk,
    input  wire logic             reset,
    apu_wave_channel_if.slave     bus,
    input  wire logic             qframe_tick_i,
    input  wire logic             hframe_tick_i,
    input  wire logic             ch_enable_i,
    output logic [OUT_W-1:0]      wave_o,
    output logic                  active_o
);

    localparam int c_IDX_W = OUT_W + 1;

    logic [TIMER_W-1:0] period_q, period_d;
    logic [TIMER_W-1:0] timer_q,  timer_d;
    logic [c_IDX_W-1:0] idx_q,    idx_d;
    logic [6:0]         linear_q, linear_d;
    logic [7:0]         length_q, length_d;
    logic [6:0]         reload_q, reload_d;
    logic               control_q, control_d;
    logic               reload_flag_q, reload_flag_d;

    logic               w_wr0, w_wr2, w_wr3;
    logic               w_step_tick;
    logic               w_advance;
    logic [TIMER_W-1:0] w_period_wr2, w_period_wr3;

    function automatic logic [7:0] len_lookup(input logic [4:0] i);
        case (i)
            5'd0:  return 8'd10;   5'd1:  return 8'd254;
            5'd2:  return 8'd20;   5'd3:  return 8'd2;
            5'd4:  return 8'd40;   5'd5:  return 8'd4;
            5'd6:  return 8'd80;   5'd7:  return 8'd6;
            5'd8:  return 8'd160;  5'd9:  return 8'd8;
            5'd10: return 8'd60;   5'd11: return 8'd10;
            5'd12: return 8'd14;   5'd13: return 8'd12;
            5'd14: return 8'd26;   5'd15: return 8'd14;
            5'd16: return 8'd12;   5'd17: return 8'd16;
            5'd18: return 8'd24;   5'd19: return 8'd18;
            5'd20: return 8'd48;   5'd21: return 8'd20;
            5'd22: return 8'd96;   5'd23: return 8'd22;
            5'd24: return 8'd192;  5'd25: return 8'd24;
            5'd26: return 8'd72;   5'd27: return 8'd26;
            5'd28: return 8'd16;   5'd29: return 8'd28;
            5'd30: return 8'd32;   default: return 8'd30;
        endcase
    endfunction

    assign w_wr0 = bus.reg_wr_en && (bus.reg_addr == 2'd0);
    assign w_wr2 = bus.reg_wr_en && (bus.reg_addr == 2'd2);
    assign w_wr3 = bus.reg_wr_en && (bus.reg_addr == 2'd3);

    // Period low byte comes from reg 2, the remaining high bits from reg 3.
    generate
        if (TIMER_W > 8) begin : g_period_hi
            assign w_period_wr2 = {period_q[TIMER_W-1:8], bus.reg_wdata};
            assign w_period_wr3 = {bus.reg_wdata[TIMER_W-9:0], period_q[7:0]};
        end else begin : g_period_lo
            assign w_period_wr2 = bus.reg_wdata[TIMER_W-1:0];
            assign w_period_wr3 = period_q;
        end
    endgenerate

    assign w_step_tick = (timer_q == '0);
    // Periods below 2 are ultrasonic: the sequencer freezes on its current
    // value rather than aliasing.
    assign w_advance   = w_step_tick && (linear_q != 7'd0) && (length_q != 8'd0)
                         && (period_q > TIMER_W'(1));

    always_comb begin
        period_d      = period_q;
        timer_d       = timer_q;
        idx_d         = idx_q;
        linear_d      = linear_q;
        length_d      = length_q;
        reload_d      = reload_q;
        control_d     = control_q;
        reload_flag_d = reload_flag_q;

        if (w_wr0) begin
            control_d = bus.reg_wdata[7];
            reload_d  = bus.reg_wdata[6:0];
        end
        if (w_wr2) period_d = w_period_wr2;
        if (w_wr3) period_d = w_period_wr3;

        timer_d = w_step_tick ? period_q : timer_q - TIMER_W'(1);

        if (w_advance) idx_d = idx_q + c_IDX_W'(1);

        if (qframe_tick_i) begin
            if (reload_flag_q)          linear_d = reload_q;
            else if (linear_q != 7'd0)  linear_d = linear_q - 7'd1;
        end

        // A reg-3 write on a quarter-frame tick sets the flag after the tick
        // has consumed the old one.
        if (w_wr3)                           reload_flag_d = 1'b1;
        else if (qframe_tick_i && !control_q) reload_flag_d = 1'b0;

        // Load takes priority over a coincident half-frame decrement.
        if (!ch_enable_i)
            length_d = 8'd0;
        else if (w_wr3)
            length_d = len_lookup(bus.reg_wdata[7:3]);
        else if (hframe_tick_i && !control_q && (length_q != 8'd0))
            length_d = length_q - 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_q      <= '0;
            timer_q       <= '0;
            idx_q         <= '0;
            linear_q      <= '0;
            length_q      <= '0;
            reload_q      <= '0;
            control_q     <= 1'b0;
            reload_flag_q <= 1'b0;
        end else begin
            period_q      <= period_d;
            timer_q       <= timer_d;
            idx_q         <= idx_d;
            linear_q      <= linear_d;
            length_q      <= length_d;
            reload_q      <= reload_d;
            control_q     <= control_d;
            reload_flag_q <= reload_flag_d;
        end
    end

    generate
        if (MODE == 0) begin : g_triangle
            // First half counts down (inverted index), second half counts up.
            assign wave_o = idx_q[OUT_W] ? idx_q[OUT_W-1:0] : ~idx_q[OUT_W-1:0];
        end else begin : g_sawtooth
            assign wave_o = idx_q[OUT_W:1];
        end
    endgenerate

    assign active_o = (length_q != 8'd0);

endmodule
`default_nettype wire
